// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: per-instruction control bundle carried ID -> EX.
package riscv_pkg;

  localparam int unsigned ALUOP_W  = 4;
  localparam logic [4:0]  REG_ZERO = 5'd0;

  typedef struct packed {
    logic               RegWrEnable;
    logic               MemRdEnable;
    logic               MemWrEnable;
    logic [ALUOP_W-1:0] AluOp;
  } idex_ctrl_t;

endpackage

// File: rtl/idex_stage_load_use_detector.sv
// Load-use hazard detect: a load sitting in EX whose RD is read by the ID instruction.
module load_use_detector
  import riscv_pkg::*;
#(
  parameter int unsigned REG_WIDTH = 5
) (
  input  logic                 ex_valid_i,
  input  logic                 ex_mem_rd_i,
  input  logic [REG_WIDTH-1:0] ex_rd_i,
  input  logic                 id_valid_i,
  input  logic [REG_WIDTH-1:0] id_rs1_i,
  input  logic [REG_WIDTH-1:0] id_rs2_i,
  input  logic                 id_uses_rs1_i,
  input  logic                 id_uses_rs2_i,
  output logic                 load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
  assign rs2_hit = id_uses_rs2_i && (id_rs2_i == ex_rd_i);

  // x0 is never a real producer, so a load to x0 cannot create a hazard.
  assign load_use_o = ex_valid_i && ex_mem_rd_i && (ex_rd_i != REG_WIDTH'(REG_ZERO)) &&
                      id_valid_i && (rs1_hit || rs2_hit);

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall/bubble insertion and a saturating bubble counter.
module idex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned REG_WIDTH   = 5,
  parameter int unsigned ALUOP_WIDTH = ALUOP_W,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  input  logic                   i_Valid,
  input  logic [REG_WIDTH-1:0]   i_InstRS1,
  input  logic [REG_WIDTH-1:0]   i_InstRS2,
  input  logic                   i_UsesRS1,
  input  logic                   i_UsesRS2,
  input  logic [REG_WIDTH-1:0]   i_InstRD,
  input  logic                   i_RegWrEnable,
  input  logic                   i_MemRdEnable,
  input  logic                   i_MemWrEnable,
  input  logic [ALUOP_WIDTH-1:0] i_AluOp,
  input  logic [DATA_WIDTH-1:0]  i_DataA,
  input  logic [DATA_WIDTH-1:0]  i_DataB,
  input  logic [DATA_WIDTH-1:0]  i_Imm,
  input  logic [PC_WIDTH-1:0]    i_PC,
  input  logic                   i_Flush,
  input  logic                   i_Hold,
  output logic                   o_Stall,
  output logic                   o_Valid,
  output logic [REG_WIDTH-1:0]   o_InstRS1,
  output logic [REG_WIDTH-1:0]   o_InstRS2,
  output logic [REG_WIDTH-1:0]   o_InstRD,
  output logic                   o_RegWrEnable,
  output logic                   o_MemRdEnable,
  output logic                   o_MemWrEnable,
  output logic [ALUOP_WIDTH-1:0] o_AluOp,
  output logic [DATA_WIDTH-1:0]  o_DataA,
  output logic [DATA_WIDTH-1:0]  o_DataB,
  output logic [DATA_WIDTH-1:0]  o_Imm,
  output logic [PC_WIDTH-1:0]    o_PC,
  output logic [CNT_WIDTH-1:0]   o_BubbleCount
);

  logic                  valid_q, valid_d;
  logic [REG_WIDTH-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  idex_ctrl_t            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  load_use;

  load_use_detector #(
    .REG_WIDTH (REG_WIDTH)
  ) u_lud (
    .ex_valid_i    (valid_q),
    .ex_mem_rd_i   (ctrl_q.MemRdEnable),
    .ex_rd_i       (rd_q),
    .id_valid_i    (i_Valid),
    .id_rs1_i      (i_InstRS1),
    .id_rs2_i      (i_InstRS2),
    .id_uses_rs1_i (i_UsesRS1),
    .id_uses_rs2_i (i_UsesRS2),
    .load_use_o    (load_use)
  );

  // Flush is deliberately excluded so the EX redirect path cannot loop back through the stall.
  assign o_Stall = load_use || i_Hold;

  always_comb begin
    valid_d = valid_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    if (i_Flush || (!i_Hold && load_use)) begin
      valid_d = 1'b0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      ctrl_d  = '0;
      a_d     = '0;
      b_d     = '0;
      imm_d   = '0;
      pc_d    = '0;
      if (!i_Flush && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (!i_Hold) begin
      valid_d            = i_Valid;
      rs1_d              = i_InstRS1;
      rs2_d              = i_InstRS2;
      rd_d               = i_InstRD;
      ctrl_d.RegWrEnable = i_RegWrEnable && i_Valid;
      ctrl_d.MemRdEnable = i_MemRdEnable && i_Valid;
      ctrl_d.MemWrEnable = i_MemWrEnable && i_Valid;
      ctrl_d.AluOp       = ALUOP_W'(i_AluOp);
      a_d                = i_DataA;
      b_d                = i_DataB;
      imm_d              = i_Imm;
      pc_d               = i_PC;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      valid_q <= 1'b0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Valid       = valid_q;
  assign o_InstRS1     = rs1_q;
  assign o_InstRS2     = rs2_q;
  assign o_InstRD      = rd_q;
  assign o_RegWrEnable = ctrl_q.RegWrEnable;
  assign o_MemRdEnable = ctrl_q.MemRdEnable;
  assign o_MemWrEnable = ctrl_q.MemWrEnable;
  assign o_AluOp       = ALUOP_WIDTH'(ctrl_q.AluOp);
  assign o_DataA       = a_q;
  assign o_DataB       = b_q;
  assign o_Imm         = imm_q;
  assign o_PC          = pc_q;
  assign o_BubbleCount = cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: load-use stalls, x0/RS2 exemptions, flush/hold priority, saturation, async reset.
module tb_idex_stage;

  logic        clk;
  logic        rst_n;
  logic        valid, uses1, uses2, we, mr, mw, flush, hold;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  aluop;
  logic [31:0] da, db, imm, pc;

  logic        stall, o_valid, o_we, o_mr, o_mw;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [3:0]  o_aluop;
  logic [31:0] o_da, o_db, o_imm, o_pc;
  logic [1:0]  o_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  idex_stage #(
    .DATA_WIDTH  (32),
    .PC_WIDTH    (32),
    .REG_WIDTH   (5),
    .ALUOP_WIDTH (4),
    .CNT_WIDTH   (2)
  ) dut (
    .i_Clock       (clk),
    .i_Reset       (rst_n),
    .i_Valid       (valid),
    .i_InstRS1     (rs1),
    .i_InstRS2     (rs2),
    .i_UsesRS1     (uses1),
    .i_UsesRS2     (uses2),
    .i_InstRD      (rd),
    .i_RegWrEnable (we),
    .i_MemRdEnable (mr),
    .i_MemWrEnable (mw),
    .i_AluOp       (aluop),
    .i_DataA       (da),
    .i_DataB       (db),
    .i_Imm         (imm),
    .i_PC          (pc),
    .i_Flush       (flush),
    .i_Hold        (hold),
    .o_Stall       (stall),
    .o_Valid       (o_valid),
    .o_InstRS1     (o_rs1),
    .o_InstRS2     (o_rs2),
    .o_InstRD      (o_rd),
    .o_RegWrEnable (o_we),
    .o_MemRdEnable (o_mr),
    .o_MemWrEnable (o_mw),
    .o_AluOp       (o_aluop),
    .o_DataA       (o_da),
    .o_DataB       (o_db),
    .o_Imm         (o_imm),
    .o_PC          (o_pc),
    .o_BubbleCount (o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one ID instruction; the tail operands and control flags are held at defaults.
  task automatic drv(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                     input logic u1, input logic u2, input logic [4:0] d,
                     input logic ld, input logic [31:0] im, input logic [31:0] p);
    valid = v;  rs1 = s1;  rs2 = s2;  uses1 = u1;  uses2 = u2;  rd = d;
    we = 1'b1;  mr = ld;   mw = 1'b0; aluop = 4'h3;
    da = 32'h1000 + p;     db = 32'h2000 + p;     imm = im;  pc = p;
  endtask

  initial begin
    rst_n = 1'b0;  flush = 1'b0;  hold = 1'b0;
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0);
    #3;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_cnt", {30'd0, o_cnt}, 32'd0);
    #9 rst_n = 1'b1;

    // load x5 followed by add x6,x5,x1
    drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'd8, 32'h100);
    step();
    chk("ld_valid", {31'd0, o_valid}, 32'd1);
    chk("ld_rd", {27'd0, o_rd}, 32'd5);
    chk("ld_mr", {31'd0, o_mr}, 32'd1);
    chk("ld_pc", o_pc, 32'h100);
    drv(1'b1, 5'd5, 5'd1, 1'b1, 1'b1, 5'd6, 1'b0, 32'd0, 32'h104);
    #1 chk("lu_stall", {31'd0, stall}, 32'd1);
    step();
    chk("bub_valid", {31'd0, o_valid}, 32'd0);
    chk("bub_we", {31'd0, o_we}, 32'd0);
    chk("bub_cnt", {30'd0, o_cnt}, 32'd1);
    chk("bub_stall", {31'd0, stall}, 32'd0);
    step();
    chk("add_valid", {31'd0, o_valid}, 32'd1);
    chk("add_rs1", {27'd0, o_rs1}, 32'd5);
    chk("add_rd", {27'd0, o_rd}, 32'd6);
    chk("add_db", o_db, 32'h2104);
    chk("add_mr", {31'd0, o_mr}, 32'd0);

    // load x0 then consumer of x0: no hazard
    drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 32'd0, 32'h108);
    step();
    drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd7, 1'b0, 32'd0, 32'h10C);
    #1 chk("x0_stall", {31'd0, stall}, 32'd0);
    step();
    chk("x0_rd", {27'd0, o_rd}, 32'd7);
    chk("x0_cnt", {30'd0, o_cnt}, 32'd1);

    // load x5 then addi x6,x7,4 with stale rs2=5 not used
    drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'd0, 32'h110);
    step();
    drv(1'b1, 5'd7, 5'd5, 1'b1, 1'b0, 5'd6, 1'b0, 32'd4, 32'h114);
    #1 chk("rs2u_stall", {31'd0, stall}, 32'd0);
    step();
    chk("addi_valid", {31'd0, o_valid}, 32'd1);
    chk("addi_pc", o_pc, 32'h114);
    chk("addi_imm", o_imm, 32'd4);

    // flush concurrent with load-use: bubble without counting
    drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'd0, 32'h118);
    step();
    drv(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd8, 1'b0, 32'd0, 32'h124);
    flush = 1'b1;
    #1 chk("fl_stall", {31'd0, stall}, 32'd1);
    step();
    flush = 1'b0;
    chk("fl_valid", {31'd0, o_valid}, 32'd0);
    chk("fl_mr", {31'd0, o_mr}, 32'd0);
    chk("fl_cnt", {30'd0, o_cnt}, 32'd1);
    step();
    chk("postfl_pc", o_pc, 32'h124);

    // hold for 3 cycles freezes EX
    drv(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd10, 1'b0, 32'd0, 32'h200);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("hold_stall", {31'd0, stall}, 32'd1);
      step();
      chk("hold_pc", o_pc, 32'h124);
      chk("hold_rd", {27'd0, o_rd}, 32'd8);
    end
    hold = 1'b0;
    step();
    chk("unhold_pc", o_pc, 32'h200);

    // five load-use pairs; counter saturates at 3; first pair also held one cycle
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'd0, 32'h300 + 32'(i * 16));
      step();
      drv(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd11, 1'b0, 32'd0, 32'h304 + 32'(i * 16));
      if (i == 0) begin
        hold = 1'b1;
        step();
        hold = 1'b0;
        chk("hlu_valid", {31'd0, o_valid}, 32'd1);
        chk("hlu_cnt", {30'd0, o_cnt}, 32'd1);
        #1 chk("hlu_stall", {31'd0, stall}, 32'd1);
      end
      step();
      chk("sat_bub", {31'd0, o_valid}, 32'd0);
      chk("sat_cnt", {30'd0, o_cnt}, (i == 0) ? 32'd2 : 32'd3);
      step();
      chk("sat_cons", {27'd0, o_rd}, 32'd11);
    end

    // async reset while a load-use stall is pending
    drv(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 32'd0, 32'h400);
    step();
    drv(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd12, 1'b0, 32'd0, 32'h404);
    #1 chk("prerst_stall", {31'd0, stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    chk("arst_pc", o_pc, 32'd0);
    chk("arst_rd", {27'd0, o_rd}, 32'd0);
    chk("arst_cnt", {30'd0, o_cnt}, 32'd0);
    chk("arst_stall", {31'd0, stall}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("postrst_pc", o_pc, 32'h404);
    chk("postrst_cnt", {30'd0, o_cnt}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
ID/EX pipeline register with integrated load-use hazard detection for the 5-stage RV32I core. It captures decoded operands and control from ID and presents them to EX. Its registered RS1/RS2 outputs drive the ALU forwarding controller's source-register inputs; its RD and enable outputs feed EX/MEM. It generates the stall to IF/ID and inserts bubbles when forwarding cannot cover a hazard.

Parameters:
DATA_WIDTH, 32, register data width
PC_WIDTH, 32, program counter width
REG_WIDTH, 5, register address width
ALUOP_WIDTH, 4, ALU operation code width
CNT_WIDTH, 16, width of the bubble performance counter

Ports:
i_Clock  in  1  clock, rising edge
i_Reset  in  1  asynchronous active-low reset
i_Valid  in  1  ID holds a valid instruction
i_InstRS1  in  REG_WIDTH  source register 1
i_InstRS2  in  REG_WIDTH  source register 2
i_UsesRS1  in  1  instruction reads RS1
i_UsesRS2  in  1  instruction reads RS2
i_InstRD  in  REG_WIDTH  destination register
i_RegWrEnable  in  1  instruction writes RD
i_MemRdEnable  in  1  instruction is a load
i_MemWrEnable  in  1  instruction is a store
i_AluOp  in  ALUOP_WIDTH  ALU operation
i_DataA  in  DATA_WIDTH  register file read of RS1
i_DataB  in  DATA_WIDTH  register file read of RS2
i_Imm  in  DATA_WIDTH  sign-extended immediate
i_PC  in  PC_WIDTH  instruction PC
i_Flush  in  1  branch/jump redirect resolved in EX, kill ID instruction
i_Hold  in  1  downstream (MEM) stall, freeze this stage
o_Stall  out  1  combinational, freeze PC and IF/ID
o_Valid  out  1  EX holds a valid instruction
o_InstRS1, o_InstRS2, o_InstRD  out  REG_WIDTH each  registered register addresses
o_RegWrEnable, o_MemRdEnable, o_MemWrEnable  out  1 each  registered control, gated by valid
o_AluOp  out  ALUOP_WIDTH  registered
o_DataA, o_DataB, o_Imm  out  DATA_WIDTH each  registered
o_PC  out  PC_WIDTH  registered
o_BubbleCount  out  CNT_WIDTH  saturating count of load-use bubbles

Behaviour:
- Reset (i_Reset=0, async): all registered outputs 0, o_Valid=0, o_BubbleCount=0. Reset mid-stall clears the bubble; no pending state survives.
- Load-use detect (combinational): LoadUse = o_Valid & o_MemRdEnable & (o_InstRD!=0) & i_Valid & ((i_UsesRS1 & i_InstRS1==o_InstRD) | (i_UsesRS2 & i_InstRS2==o_InstRD)).
- o_Stall = LoadUse | i_Hold. No dependence on i_Flush, so there is no combinational loop.
- Per rising edge, priority high to low:
  1. i_Flush=1: load a bubble. o_Valid=0; RegWr/MemRd/MemWr=0; other fields don't-care, RTL zeroes them.
  2. i_Hold=1: all registers keep their value.
  3. LoadUse=1: load a bubble and increment o_BubbleCount, saturating at all-ones.
  4. Otherwise capture ID inputs, o_Valid=i_Valid. Enables are ANDed with i_Valid.
- Latency: 1 cycle, ID to EX.
- The load-use stall lasts exactly 1 cycle. The bubble clears o_Valid, so LoadUse deasserts. The consumer then gets its operand from the MEM/WB forward path.
- RD=x0 never stalls. An instruction without RS2 (i_UsesRS2=0) never stalls on RS2 match.
- Flush and LoadUse in the same cycle: flush wins and the counter does not increment.
- Hold and LoadUse together: hold wins, the stage freezes, and LoadUse is re-evaluated next cycle.

Decomposition:
- Shared package riscv_pkg: idex_ctrl_t struct (RegWrEnable, MemRdEnable, MemWrEnable, AluOp); constant REG_ZERO.
- Sub-module load_use_detector: the LoadUse equation only, combinational. It is instantiated once; the registers live in idex_stage.

Test Plan:
- Reset: i_Reset=0 mid-operation with o_Valid=1 -> all outputs 0 immediately, asynchronously, before the next clock edge.
- Load x5 then add x6,x5,x1 back-to-back -> o_Stall=1 for exactly 1 cycle; next edge gives o_Valid=0 bubble and o_BubbleCount=1; following edge captures the add with o_InstRS1=5.
- Load x0 then consumer reading x0 -> o_Stall=0, no bubble.
- Load x5 then addi x6,x7,4 with i_InstRS2=5 and i_UsesRS2=0 -> o_Stall=0, addi captured next edge.
- i_Flush=1 concurrent with LoadUse -> bubble inserted, o_BubbleCount unchanged; i_Hold=1 for 3 cycles -> outputs frozen, o_Stall=1 throughout.
- CNT_WIDTH=2 with 5 consecutive load-use pairs -> o_BubbleCount saturates at 3.
